// File: rtl/sht_meas_sequencer.sv
// I2C master and sequencer for one SHT3x single-shot measurement: command write, conversion wait, 6-byte read.
// Define SHT_CRC_CHECK_EN to build the CRC-8 checker; without it crc_err is tied to 2'b00.
module sht_meas_sequencer #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h44,
    parameter logic [15:0] MEAS_CMD   = 16'h2400,
    parameter int          CLK_DIV    = 125,
    parameter int          MEAS_WAIT  = 750000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] temp,
    output logic [15:0] hum,
    output logic [1:0]  crc_err,
    output logic        nack_err,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        sda_i,
    output logic [3:0]  state_dbg
);

    // Handshake: start is a one-cycle request taken only in IDLE; busy rises the next cycle and
    // drops in the single FINISH cycle, where done pulses once with all result outputs already valid.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_W_START = 4'd1,
        ST_W_ADDR  = 4'd2,
        ST_W_CMD_M = 4'd3,
        ST_W_CMD_L = 4'd4,
        ST_W_STOP  = 4'd5,
        ST_WAIT    = 4'd6,
        ST_R_START = 4'd7,
        ST_R_ADDR  = 4'd8,
        ST_R_DATA  = 4'd9,
        ST_R_STOP  = 4'd10,
        ST_FINISH  = 4'd11
    } state_t;

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int WW = (MEAS_WAIT > 1) ? $clog2(MEAS_WAIT + 1) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MEAS_WAIT - 1);

    state_t        state_q, state_d;
    logic [DW-1:0] div_q;
    logic [WW-1:0] wait_q;
    logic [1:0]    qtr_q;
    logic [3:0]    bit_q;
    logic [2:0]    byte_q;
    logic          ack_q;
    logic          nack_q;
    logic [6:0]    rx_q;
    logic [15:0]   t_word_q, h_word_q;
    logic [15:0]   temp_q, hum_q;
    logic          nack_err_q;
    logic          scl_oe_q, sda_oe_q;
    logic          scl_oe_d, sda_oe_d;
    logic [7:0]    tx_byte;
    logic [7:0]    rx_byte;
    logic          timed, byte_st, tick, sample, bit_end, last_bit, accept, fin;

    assign timed    = !(state_q inside {ST_IDLE, ST_WAIT, ST_FINISH});
    assign byte_st  = state_q inside {ST_W_ADDR, ST_W_CMD_M, ST_W_CMD_L, ST_R_ADDR, ST_R_DATA};
    assign tick     = timed && (div_q == DIV_LAST);
    assign sample   = tick && (qtr_q == 2'd2);
    assign bit_end  = tick && (qtr_q == 2'd3);
    assign last_bit = (bit_q == 4'd8);
    assign accept   = (state_q == ST_IDLE) && start;
    assign fin      = (state_d == ST_FINISH);
    assign rx_byte  = {rx_q, sda_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_W_START;
            ST_W_START: if (bit_end) state_d = ST_W_ADDR;
            ST_W_ADDR:  if (bit_end && last_bit) state_d = ack_q ? ST_W_STOP : ST_W_CMD_M;
            ST_W_CMD_M: if (bit_end && last_bit) state_d = ack_q ? ST_W_STOP : ST_W_CMD_L;
            ST_W_CMD_L: if (bit_end && last_bit) state_d = ST_W_STOP;
            ST_W_STOP:  if (bit_end) state_d = nack_q ? ST_FINISH : ST_WAIT;
            ST_WAIT:    if (wait_q == WAIT_LAST) state_d = ST_R_START;
            ST_R_START: if (bit_end) state_d = ST_R_ADDR;
            ST_R_ADDR:  if (bit_end && last_bit) state_d = ack_q ? ST_R_STOP : ST_R_DATA;
            ST_R_DATA:  if (bit_end && last_bit && (byte_q == 3'd5)) state_d = ST_R_STOP;
            ST_R_STOP:  if (bit_end) state_d = ST_FINISH;
            ST_FINISH:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_byte  = 8'h00;
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state_q)
            ST_W_ADDR:  tx_byte = {SLAVE_ADDR, 1'b0};
            ST_W_CMD_M: tx_byte = MEAS_CMD[15:8];
            ST_W_CMD_L: tx_byte = MEAS_CMD[7:0];
            ST_R_ADDR:  tx_byte = {SLAVE_ADDR, 1'b1};
            default:    tx_byte = 8'h00;
        endcase
        case (state_q)
            ST_IDLE:   busy = 1'b0;
            ST_FINISH: begin
                busy = 1'b0;
                done = 1'b1;
            end
            ST_W_START, ST_R_START: sda_oe_d = qtr_q[1];
            ST_W_STOP, ST_R_STOP: begin
                scl_oe_d = (qtr_q == 2'd0);
                sda_oe_d = ~qtr_q[1];
            end
            ST_W_ADDR, ST_W_CMD_M, ST_W_CMD_L, ST_R_ADDR: begin
                scl_oe_d = ~qtr_q[1];
                sda_oe_d = !last_bit && !tx_byte[3'd7 - bit_q[2:0]];
            end
            // Receive: ACK bytes 0-4, leave the bus released (NACK) after byte 5.
            ST_R_DATA: begin
                scl_oe_d = ~qtr_q[1];
                sda_oe_d = last_bit && (byte_q != 3'd5);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= '0;
            wait_q     <= '0;
            qtr_q      <= 2'd0;
            bit_q      <= 4'd0;
            byte_q     <= 3'd0;
            ack_q      <= 1'b0;
            nack_q     <= 1'b0;
            rx_q       <= 7'd0;
            t_word_q   <= 16'h0000;
            h_word_q   <= 16'h0000;
            temp_q     <= 16'h0000;
            hum_q      <= 16'h0000;
            nack_err_q <= 1'b0;
            scl_oe_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
        end else begin
            scl_oe_q <= scl_oe_d;
            sda_oe_q <= sda_oe_d;
            div_q    <= (!timed || tick) ? '0 : div_q + 1'b1;
            wait_q   <= (state_q == ST_WAIT) ? wait_q + 1'b1 : '0;
            qtr_q    <= !timed ? 2'd0 : (tick ? qtr_q + 2'd1 : qtr_q);
            if (!byte_st) begin
                bit_q <= 4'd0;
            end else if (bit_end) begin
                bit_q <= last_bit ? 4'd0 : bit_q + 4'd1;
            end
            if (state_q != ST_R_DATA) begin
                byte_q <= 3'd0;
            end else if (bit_end && last_bit) begin
                byte_q <= byte_q + 3'd1;
            end
            if (byte_st && sample && last_bit) begin
                ack_q <= sda_i;
            end
            if (accept) begin
                nack_q     <= 1'b0;
                nack_err_q <= 1'b0;
            end else if (bit_end && last_bit && ack_q &&
                         (state_q inside {ST_W_ADDR, ST_W_CMD_M, ST_W_CMD_L, ST_R_ADDR})) begin
                nack_q <= 1'b1;
            end
            if (state_q == ST_R_DATA && sample && !last_bit) begin
                rx_q <= rx_byte[6:0];
                if (bit_q == 4'd7) begin
                    case (byte_q)
                        3'd0:    t_word_q[15:8] <= rx_byte;
                        3'd1:    t_word_q[7:0]  <= rx_byte;
                        3'd3:    h_word_q[15:8] <= rx_byte;
                        3'd4:    h_word_q[7:0]  <= rx_byte;
                        default: ;
                    endcase
                end
            end
            // Results are loaded on entry to FINISH so they are valid while done is high.
            if (fin) begin
                nack_err_q <= nack_q;
                if (!nack_q) begin
                    temp_q <= t_word_q;
                    hum_q  <= h_word_q;
                end
            end
        end
    end

`ifdef SHT_CRC_CHECK_EN
    logic [7:0] crc_q;
    logic [7:0] crc_step;
    logic [1:0] crc_bad_q;
    logic [1:0] crc_err_q;

    assign crc_step = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ sda_i) ? 8'h31 : 8'h00);

    // Bytes 2 and 5 are compared against the running CRC, which then restarts for the next word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q     <= 8'hFF;
            crc_bad_q <= 2'b00;
            crc_err_q <= 2'b00;
        end else begin
            if (state_q != ST_R_DATA) begin
                crc_q <= 8'hFF;
            end else if (sample && !last_bit) begin
                if (byte_q == 3'd2 || byte_q == 3'd5) begin
                    if (bit_q == 4'd7) begin
                        crc_q <= 8'hFF;
                        if (byte_q == 3'd2) crc_bad_q[0] <= (rx_byte != crc_q);
                        else                crc_bad_q[1] <= (rx_byte != crc_q);
                    end
                end else begin
                    crc_q <= crc_step;
                end
            end
            if (accept) begin
                crc_bad_q <= 2'b00;
                crc_err_q <= 2'b00;
            end else if (fin && !nack_q) begin
                crc_err_q <= crc_bad_q;
            end
        end
    end

    assign crc_err = crc_err_q;
`else
    assign crc_err = 2'b00;
`endif

    assign temp      = temp_q;
    assign hum       = hum_q;
    assign nack_err  = nack_err_q;
    assign scl_oe    = scl_oe_q;
    assign sda_oe    = sda_oe_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_sht_meas_sequencer.sv
// Directed bench for sht_meas_sequencer with a simple SHT3x-like slave on a wired-AND bus.
// CRC expectations follow SHT_CRC_CHECK_EN: with it undefined crc_err must stay 2'b00.
module tb_sht_meas_sequencer;

    localparam int CLK_DIV   = 4;
    localparam int MEAS_WAIT = 100;
    localparam int LIMIT     = 3000;
    // START 4Q, three 9-bit write bytes, STOP 4Q, wait, START 4Q, address + six read bytes, STOP 4Q.
    localparam int FULL_BUSY = (4 + 3 * 36 + 4) * CLK_DIV + MEAS_WAIT + (4 + 7 * 36 + 4) * CLK_DIV;
    // START 4Q, address byte 36Q, STOP 4Q.
    localparam int NACK_BUSY = (4 + 36 + 4) * CLK_DIV;
    localparam logic [3:0] ST_WAIT   = 4'd6;
    localparam logic [3:0] ST_R_DATA = 4'd9;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy, done, nack_err, scl_oe, sda_oe;
    logic [15:0] temp, hum;
    logic [1:0]  crc_err;
    logic [3:0]  state_dbg;
    logic        scl_bus, sda_bus;

    int n_checks;
    int n_bad;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    logic [6:0] s_addr;
    logic [7:0] s_data[6];
    logic       s_scl_p, s_sda_p, s_on, s_addr_ph, s_rw, s_tx, s_mack, s_drive;
    int         s_bit, s_idx;
    logic [7:0] s_sh, s_txb;

    assign scl_bus = !scl_oe;
    assign sda_bus = !(sda_oe || s_drive);

    sht_meas_sequencer #(
        .SLAVE_ADDR(7'h44),
        .MEAS_CMD  (16'h2400),
        .CLK_DIV   (CLK_DIV),
        .MEAS_WAIT (MEAS_WAIT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .temp     (temp),
        .hum      (hum),
        .crc_err  (crc_err),
        .nack_err (nack_err),
        .scl_oe   (scl_oe),
        .sda_oe   (sda_oe),
        .sda_i    (sda_bus),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = !clk;

    // Slave: samples the bus each system clock, changes SDA only after it has seen SCL fall.
    always @(posedge clk) begin
        if (!rst_n) begin
            s_scl_p <= 1'b1; s_sda_p <= 1'b1; s_on <= 1'b0; s_addr_ph <= 1'b0; s_rw <= 1'b0;
            s_tx <= 1'b0; s_mack <= 1'b0; s_drive <= 1'b0; s_bit <= -1; s_idx <= 0;
            s_sh <= 8'h00; s_txb <= 8'h00;
        end else begin
            s_scl_p <= scl_bus;
            s_sda_p <= sda_bus;
            if (s_scl_p && scl_bus && s_sda_p && !sda_bus) begin
                s_bit <= -1; s_addr_ph <= 1'b1; s_on <= 1'b1; s_tx <= 1'b0; s_drive <= 1'b0;
            end else if (s_scl_p && scl_bus && !s_sda_p && sda_bus) begin
                s_on <= 1'b0; s_tx <= 1'b0; s_drive <= 1'b0;
            end else if (s_on && !s_scl_p && scl_bus) begin
                if (s_bit >= 0 && s_bit < 8 && !s_tx) begin
                    s_sh <= {s_sh[6:0], sda_bus};
                    if (s_bit == 7) got_q.push_back({s_sh[6:0], sda_bus});
                end
                if (s_bit == 8 && s_tx) s_mack <= !sda_bus;
            end else if (s_on && s_scl_p && !scl_bus) begin
                if (s_bit == 7) begin
                    s_bit <= 8;
                    if (s_tx) begin
                        s_drive <= 1'b0;
                    end else if (s_addr_ph) begin
                        if (s_sh[7:1] == s_addr) begin
                            s_drive <= 1'b1;
                            s_rw    <= s_sh[0];
                        end else begin
                            s_drive <= 1'b0;
                            s_on    <= 1'b0;
                        end
                    end else begin
                        s_drive <= 1'b1;
                    end
                end else if (s_bit == 8) begin
                    s_bit     <= 0;
                    s_addr_ph <= 1'b0;
                    if (s_addr_ph && s_rw) begin
                        s_tx    <= 1'b1;
                        s_idx   <= 0;
                        s_txb   <= s_data[0];
                        s_drive <= !s_data[0][7];
                    end else if (!s_addr_ph && s_tx && s_mack && s_idx < 5) begin
                        s_idx   <= s_idx + 1;
                        s_txb   <= s_data[s_idx + 1];
                        s_drive <= !s_data[s_idx + 1][7];
                    end else begin
                        s_tx    <= 1'b0;
                        s_drive <= 1'b0;
                    end
                end else begin
                    s_bit <= s_bit + 1;
                    if (s_tx && s_bit >= 0) s_drive <= !s_txb[6 - s_bit];
                    else                    s_drive <= 1'b0;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] crc_exp(input logic [1:0] v);
`ifdef SHT_CRC_CHECK_EN
        return v;
`else
        return 2'b00;
`endif
    endfunction

    task automatic load_slave(input logic [6:0] addr, input logic [47:0] data);
        s_addr = addr;
        for (int i = 0; i < 6; i++) s_data[i] = data[47 - 8 * i -: 8];
    endtask

    // Scoreboard: bytes the slave received since index base must equal exp_q.
    task automatic check_bytes(input string tag, input int base);
        check_eq({tag, " byte count"}, got_q.size() - base, exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (base + k < got_q.size()) check_eq({tag, " bus byte"}, got_q[base + k], exp_q[k]);
        end
    endtask

    task automatic run_txn(input string tag, input logic [6:0] addr, input logic [47:0] data,
                           input bit start_on_done, input int exp_busy,
                           input logic [15:0] exp_t, input logic [15:0] exp_h,
                           input logic [1:0] exp_crc, input logic exp_nack);
        int  base, busy_n, done_n, post;
        bit  seen;
        base = got_q.size();
        exp_q.delete();
        exp_q.push_back(8'h88);
        if (!exp_nack) begin
            exp_q.push_back(8'h24);
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h89);
        end
        load_slave(addr, data);
        busy_n = 0; done_n = 0; post = 0; seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < LIMIT && post < 6; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (!seen && start_on_done) start = 1'b1;
                seen = 1'b1;
            end
            if (seen) post++;
        end
        start = 1'b0;
        check_eq({tag, " done seen"}, seen, 1);
        check_eq({tag, " done pulses"}, done_n, 1);
        check_eq({tag, " busy cycles"}, busy_n, exp_busy);
        check_eq({tag, " temp"}, temp, exp_t);
        check_eq({tag, " hum"}, hum, exp_h);
        check_eq({tag, " crc_err"}, crc_err, crc_exp(exp_crc));
        check_eq({tag, " nack_err"}, nack_err, exp_nack);
        check_bytes(tag, base);
    endtask

    initial begin
        int  base;
        bit  hit;
        n_checks = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        load_slave(7'h44, 48'h6332A18CA4DB);
        repeat (3) @(negedge clk);
        check_eq("reset busy", busy, 0);
        check_eq("reset done", done, 0);
        check_eq("reset temp", temp, 0);
        check_eq("reset hum", hum, 0);
        check_eq("reset crc_err", crc_err, 0);
        check_eq("reset nack_err", nack_err, 0);
        check_eq("reset scl_oe", scl_oe, 0);
        check_eq("reset sda_oe", sda_oe, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        run_txn("default", 7'h44, 48'h6332A18CA4DB, 1'b0, FULL_BUSY, 16'h6332, 16'h8CA4, 2'b11, 1'b0);
        run_txn("good_crc", 7'h44, 48'h63325E8CA42E, 1'b1, FULL_BUSY, 16'h6332, 16'h8CA4, 2'b00, 1'b0);
        run_txn("beef", 7'h44, 48'hBEEF92BEEF92, 1'b0, FULL_BUSY, 16'hBEEF, 16'hBEEF, 2'b00, 1'b0);
        run_txn("hum_bad", 7'h44, 48'hBEEF92BEEF00, 1'b0, FULL_BUSY, 16'hBEEF, 16'hBEEF, 2'b10, 1'b0);
        run_txn("temp_bad", 7'h44, 48'h6332008CA42E, 1'b0, FULL_BUSY, 16'h6332, 16'h8CA4, 2'b01, 1'b0);
        run_txn("addr_nack", 7'h45, 48'hBEEF92BEEF92, 1'b0, NACK_BUSY, 16'h6332, 16'h8CA4, 2'b00, 1'b1);

        // Second start during WAIT, then reset in the middle of the read.
        load_slave(7'h44, 48'h6332A18CA4DB);
        base = got_q.size();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < LIMIT && !hit; i++) begin
            @(negedge clk);
            if (state_dbg == ST_WAIT) hit = 1'b1;
        end
        check_eq("reach wait", hit, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("start in wait ignored", state_dbg, ST_WAIT);
        check_eq("busy in wait", busy, 1);
        hit = 1'b0;
        for (int i = 0; i < LIMIT && !hit; i++) begin
            @(negedge clk);
            if (state_dbg == ST_R_DATA) hit = 1'b1;
        end
        check_eq("reach read data", hit, 1);
        repeat (2) @(negedge clk);
        check_eq("scl low before reset", scl_oe, 1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst scl_oe", scl_oe, 0);
        check_eq("rst sda_oe", sda_oe, 0);
        check_eq("rst busy", busy, 0);
        exp_q.delete();
        exp_q.push_back(8'h88);
        exp_q.push_back(8'h24);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h89);
        check_bytes("busy_start", base);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("post reset temp", temp, 0);
        check_eq("post reset nack_err", nack_err, 0);
        run_txn("after_reset", 7'h44, 48'h63325E8CA42E, 1'b0, FULL_BUSY, 16'h6332, 16'h8CA4, 2'b00, 1'b0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
